// File: rtl/fft_pkg.sv
// Shared types and constants for the in-place radix-2 FFT sequencer.
// sample_t packs one complex sample as {real, imag} signed 16-bit halves.
package fft_pkg;

  localparam int LOG2N_DEFAULT = 4;
  localparam int N             = 1 << LOG2N_DEFAULT;
  localparam int HALF_N        = N / 2;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } sample_t;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    EX,
    WR,
    FIN
  } state_t;

  // Arithmetic halving of both components, used for per-stage 1/2 scaling.
  function automatic sample_t halve(input sample_t x);
    sample_t y;
    y.re = x.re >>> 1;
    y.im = x.im >>> 1;
    return y;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address generator: (bf_idx, stage) -> RAM pair and twiddle index.
// Pure function of its inputs so a pipelined sequencer can reuse it unchanged.
module fft_addr_gen #(
  parameter int LOG2N = 4
) (
  input  logic [LOG2N-2:0] bf_idx,
  input  logic [LOG2N-1:0] s,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_addr
);

  logic [LOG2N-1:0] idx_ext;
  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] low_mask;
  logic [LOG2N-1:0] j;
  logic [LOG2N-1:0] tw_full;

  always_comb begin
    idx_ext  = {1'b0, bf_idx};
    span     = LOG2N'(1) << s;
    low_mask = span - LOG2N'(1);
    j        = idx_ext & low_mask;
    // A zero bit is opened at position s: upper bits move up one place.
    addr_a   = ((idx_ext & ~low_mask) << 1) | j;
    addr_b   = addr_a | span;
    tw_full  = j << (LOG2N - 1 - int'(s));
    tw_addr  = tw_full[LOG2N-2:0];
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIT FFT controller: one butterfly per RD/EX/WR triple, LOG2N stages of N/2.
// Build macro FFT_SCALE_EN: results are arithmetically halved per component every stage.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEFAULT,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [LOG2N-1:0] stage,
  output logic [LOG2N-1:0] mem_addr_a,
  output logic [LOG2N-1:0] mem_addr_b,
  input  logic [DW-1:0]    mem_rdata_a,
  input  logic [DW-1:0]    mem_rdata_b,
  output logic             mem_we,
  output logic [DW-1:0]    mem_wdata_a,
  output logic [DW-1:0]    mem_wdata_b,
  output logic [LOG2N-2:0] tw_addr,
  input  logic [DW-1:0]    tw_data,
  output logic [DW-1:0]    bf_a,
  output logic [DW-1:0]    bf_b,
  output logic [DW-1:0]    bf_w,
  input  logic [DW-1:0]    bf_out1,
  input  logic [DW-1:0]    bf_out2
);

  // state | meaning
  // IDLE  | waiting for start
  // RD    | addresses presented to RAM and twiddle ROM
  // EX    | read data on butterfly operands, results captured at cycle end
  // WR    | results written back in place, advance butterfly/stage
  // FIN   | one-cycle done pulse

  localparam logic [LOG2N-2:0] LAST_BF = '1;
  localparam logic [LOG2N-1:0] LAST_S  = LOG2N'(LOG2N - 1);

  state_t           state;
  state_t           state_nxt;
  logic [LOG2N-2:0] bf_idx;
  logic [LOG2N-2:0] bf_idx_nxt;
  logic [LOG2N-1:0] s;
  logic [LOG2N-1:0] s_nxt;
  logic [DW-1:0]    res1;
  logic [DW-1:0]    res2;
  logic [DW-1:0]    res1_d;
  logic [DW-1:0]    res2_d;
  logic [LOG2N-1:0] gen_a;
  logic [LOG2N-1:0] gen_b;
  logic [LOG2N-2:0] gen_tw;

  fft_addr_gen #(
    .LOG2N (LOG2N)
  ) u_addr_gen (
    .bf_idx  (bf_idx),
    .s       (s),
    .addr_a  (gen_a),
    .addr_b  (gen_b),
    .tw_addr (gen_tw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      bf_idx <= '0;
      s      <= '0;
      res1   <= '0;
      res2   <= '0;
    end else begin
      state  <= state_nxt;
      bf_idx <= bf_idx_nxt;
      s      <= s_nxt;
      if (state == EX) begin
        res1 <= res1_d;
        res2 <= res2_d;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    bf_idx_nxt = bf_idx;
    s_nxt      = s;
    unique case (state)
      IDLE: if (start) state_nxt = RD;
      RD:   state_nxt = EX;
      EX:   state_nxt = WR;
      WR: begin
        state_nxt = RD;
        if (bf_idx == LAST_BF) begin
          bf_idx_nxt = '0;
          if (s == LAST_S) begin
            s_nxt     = '0;
            state_nxt = FIN;
          end else begin
            s_nxt = s + 1'b1;
          end
        end else begin
          bf_idx_nxt = bf_idx + 1'b1;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FFT_SCALE_EN
  assign res1_d = DW'(halve(sample_t'(bf_out1)));
  assign res2_d = DW'(halve(sample_t'(bf_out2)));
`else
  assign res1_d = bf_out1;
  assign res2_d = bf_out2;
`endif

  // Outputs decode straight from the state register so async reset clears them at once.
  assign busy   = (state == RD) || (state == EX) || (state == WR);
  assign done   = (state == FIN);
  assign mem_we = (state == WR);
  assign stage  = s;

  assign mem_addr_a = busy ? gen_a  : '0;
  assign mem_addr_b = busy ? gen_b  : '0;
  assign tw_addr    = busy ? gen_tw : '0;

  assign bf_a = (state == EX) ? mem_rdata_a : '0;
  assign bf_b = (state == EX) ? mem_rdata_b : '0;
  assign bf_w = (state == EX) ? tw_data     : '0;

  assign mem_wdata_a = res1;
  assign mem_wdata_b = res2;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: behavioural RAM/ROM, Q15 butterfly, golden in-place FFT model.
`timescale 1ns/1ps
module tb_fft_stage_sequencer;

  localparam int LOG2N = 4;
  localparam int N     = 16;
  localparam int NBF   = 32;

  // Q15 twiddles {cos, -sin} for k = 0..7 of a 16-point transform
  localparam logic [31:0] TW [8] = '{
    32'h7FFF_0000, 32'h7641_CF05, 32'h5A82_A57E, 32'h30FB_89BF,
    32'h0000_8001, 32'hCF05_89BF, 32'hA57E_A57E, 32'h89BF_CF05
  };

  typedef struct {
    int s;
    int bf;
    int a;
    int b;
    int tw;
  } trace_vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, mem_we;
  logic [3:0]  stage, mem_addr_a, mem_addr_b;
  logic [2:0]  tw_addr;
  logic [31:0] mem_rdata_a, mem_rdata_b, mem_wdata_a, mem_wdata_b, tw_data;
  logic [31:0] bf_a, bf_b, bf_w, bf_out1, bf_out2;

  logic [31:0] ram      [N];
  logic [31:0] init_ram [N];
  logic [31:0] gold     [N];
  logic        do_load = 1'b0;

  int exp_s [NBF];
  int exp_a [NBF];
  int exp_b [NBF];
  int exp_tw[NBF];
  int tr_s  [64];
  int tr_a  [64];
  int tr_b  [64];
  int tr_tw [64];
  int trace_n;
  int done_cyc;
  int busy_cyc;
  int total = 0;
  int bad   = 0;
  trace_vec_t tv [8];

  always #5 clk = ~clk;

  fft_stage_sequencer #(.LOG2N(LOG2N), .DW(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .stage       (stage),
    .mem_addr_a  (mem_addr_a),
    .mem_addr_b  (mem_addr_b),
    .mem_rdata_a (mem_rdata_a),
    .mem_rdata_b (mem_rdata_b),
    .mem_we      (mem_we),
    .mem_wdata_a (mem_wdata_a),
    .mem_wdata_b (mem_wdata_b),
    .tw_addr     (tw_addr),
    .tw_data     (tw_data),
    .bf_a        (bf_a),
    .bf_b        (bf_b),
    .bf_w        (bf_w),
    .bf_out1     (bf_out1),
    .bf_out2     (bf_out2)
  );

  // Q15 complex butterfly: out1 = a + b*w, out2 = a - b*w, products truncated, sums wrap.
  function automatic logic [63:0] bfly(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] w);
    longint ar, ai, br, bi, wr, wi, pr, pi;
    ar = longint'($signed(a[31:16]));
    ai = longint'($signed(a[15:0]));
    br = longint'($signed(b[31:16]));
    bi = longint'($signed(b[15:0]));
    wr = longint'($signed(w[31:16]));
    wi = longint'($signed(w[15:0]));
    pr = (br * wr - bi * wi) >>> 15;
    pi = (br * wi + bi * wr) >>> 15;
    return {16'(ar + pr), 16'(ai + pi), 16'(ar - pr), 16'(ai - pi)};
  endfunction

  function automatic logic [31:0] scl(input logic [31:0] x);
`ifdef FFT_SCALE_EN
    logic signed [15:0] re, im;
    re = $signed(x[31:16]) >>> 1;
    im = $signed(x[15:0]) >>> 1;
    return {re, im};
`else
    return x;
`endif
  endfunction

  always_comb {bf_out1, bf_out2} = bfly(bf_a, bf_b, bf_w);

  always @(posedge clk) begin
    if (do_load) begin
      for (int i = 0; i < N; i++) ram[i] <= init_ram[i];
    end else if (mem_we) begin
      ram[mem_addr_a] <= mem_wdata_a;
      ram[mem_addr_b] <= mem_wdata_b;
    end
    mem_rdata_a <= ram[mem_addr_a];
    mem_rdata_b <= ram[mem_addr_b];
    tw_data     <= TW[tw_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic load_ram();
    @(negedge clk);
    do_load = 1'b1;
    @(negedge clk);
    do_load = 1'b0;
  endtask

  // Golden in-place DIT transform: groups of 2*span, butterflies j inside a group.
  task automatic golden();
    int n;
    n = 0;
    for (int i = 0; i < N; i++) gold[i] = init_ram[i];
    for (int s = 0; s < LOG2N; s++) begin
      int span;
      span = 1 << s;
      for (int grp = 0; grp < N; grp += 2 * span) begin
        for (int j = 0; j < span; j++) begin
          int a, b, k;
          logic [63:0] r;
          a = grp + j;
          b = a + span;
          k = j * (N >> (s + 1));
          r = bfly(gold[a], gold[b], TW[k]);
          gold[a] = scl(r[63:32]);
          gold[b] = scl(r[31:0]);
          exp_s[n] = s; exp_a[n] = a; exp_b[n] = b; exp_tw[n] = k;
          n++;
        end
      end
    end
  endtask

  // Cycle 1 is the first cycle after the edge that samples start.
  task automatic run(input bit restarts, input bit fin_start);
    int cyc;
    trace_n  = 0;
    done_cyc = -1;
    busy_cyc = 0;
    cyc      = 0;
    @(negedge clk);
    start = 1'b1;
    while (cyc < 200 && done_cyc < 0) begin
      @(posedge clk);
      cyc++;
      #1;
      start = restarts && (cyc == 10 || cyc == 50);
      @(negedge clk);
      if (busy) busy_cyc++;
      if (mem_we && trace_n < 64) begin
        tr_s[trace_n]  = int'(stage);
        tr_a[trace_n]  = int'(mem_addr_a);
        tr_b[trace_n]  = int'(mem_addr_b);
        tr_tw[trace_n] = int'(tw_addr);
        trace_n++;
      end
      if (done) begin
        done_cyc = cyc;
        chk("busy low in fin", busy, 0);
      end
    end
    start = fin_start;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("idle after fin busy", {busy, done}, 0);
    @(negedge clk);
    chk("still idle busy", busy, 0);
  endtask

  task automatic check_transform(input string tag);
    chk({tag, " done cycle"}, done_cyc, 97);
    chk({tag, " busy cycles"}, busy_cyc, 96);
    chk({tag, " trace length"}, trace_n, NBF);
    for (int i = 0; i < NBF && i < trace_n; i++)
      chk({tag, " trace s/a/b/tw"}, {tr_s[i][7:0], tr_a[i][7:0], tr_b[i][7:0], tr_tw[i][7:0]},
          {exp_s[i][7:0], exp_a[i][7:0], exp_b[i][7:0], exp_tw[i][7:0]});
    for (int i = 0; i < N; i++) chk({tag, " ram word"}, ram[i], gold[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tv[0] = '{s: 0, bf: 0, a: 0,  b: 1,  tw: 0};
    tv[1] = '{s: 0, bf: 7, a: 14, b: 15, tw: 0};
    tv[2] = '{s: 1, bf: 0, a: 0,  b: 2,  tw: 0};
    tv[3] = '{s: 1, bf: 1, a: 1,  b: 3,  tw: 4};
    tv[4] = '{s: 1, bf: 2, a: 4,  b: 6,  tw: 0};
    tv[5] = '{s: 2, bf: 3, a: 3,  b: 7,  tw: 6};
    tv[6] = '{s: 2, bf: 5, a: 9,  b: 13, tw: 2};
    tv[7] = '{s: 3, bf: 5, a: 5,  b: 13, tw: 5};

    // Reset state
    #2;
    chk("reset busy/done/we", {busy, done, mem_we}, 0);
    chk("reset addr a/b/tw", {mem_addr_a, mem_addr_b, tw_addr}, 0);
    chk("reset stage", stage, 0);
    chk("reset wdata", {mem_wdata_a, mem_wdata_b}, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // All-zero RAM, plus address spot checks from the vector table
    for (int i = 0; i < N; i++) init_ram[i] = 32'h0;
    load_ram();
    golden();
    run(1'b0, 1'b0);
    check_transform("zero");
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = tv[i].s * 8 + tv[i].bf;
      chk("table trace", {tr_s[idx][7:0], tr_a[idx][7:0], tr_b[idx][7:0], tr_tw[idx][7:0]},
          {tv[i].s[7:0], tv[i].a[7:0], tv[i].b[7:0], tv[i].tw[7:0]});
    end

    // Impulse at RAM[0]
    for (int i = 0; i < N; i++) init_ram[i] = 32'h0;
    init_ram[0] = 32'h0010_0000;
    load_ram();
    golden();
    run(1'b0, 1'b0);
    check_transform("impulse");
    for (int i = 0; i < N; i++)
`ifdef FFT_SCALE_EN
      chk("impulse const", ram[i], 32'h0001_0000);
`else
      chk("impulse const", ram[i], 32'h0010_0000);
`endif

    // start re-pulsed while busy and coincident with FIN: all ignored
    for (int i = 0; i < N; i++) init_ram[i] = $urandom;
    load_ram();
    golden();
    run(1'b1, 1'b1);
    check_transform("restart");

    // Reset asserted mid-transform during a write cycle, then a clean rerun
    for (int i = 0; i < N; i++) init_ram[i] = $urandom;
    load_ram();
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 42; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    @(negedge clk);
    chk("pre-reset busy/we", {busy, mem_we}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset busy/we/done", {busy, mem_we, done}, 0);
    chk("async reset addr", {mem_addr_a, mem_addr_b, tw_addr, stage}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    load_ram();
    golden();
    run(1'b0, 1'b0);
    check_transform("post-reset");

    // Random transforms against the golden model
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < N; i++) init_ram[i] = $urandom;
      load_ram();
      golden();
      run(1'b0, 1'b0);
      check_transform("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
